alu_num_display: RTL and testbench

// - 32-bit combinational ALU (8 ops, 5 status flags) plus an 8-digit multiplexed hex seven-segment driver.
// - Sits under the board top level. The top latches A/B/op from switches, selects the display word, and routes flags to LEDs.
// - ALU and display are independent: disp_data is not tied internally to f.

---
 rtl/alu_num_display.sv | 95 +++++++++
 tb/tb_alu_num_display.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_num_display.sv
// alu_num_display: 32-bit combinational ALU plus an 8-digit multiplexed hex seven-segment driver.
// Build option LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module alu_num_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] f,
  output logic        zf,
  output logic        of,
  output logic        sf,
  output logic        cf,
  output logic        pf,
  input  logic [31:0] disp_data,
  output logic [2:0]  which,
  output logic [7:0]  seg
);
  localparam logic [19:0] LAST = 20'(SCAN_DIV - 1);
  logic [32:0] sum, diff;
  logic [19:0] presc_q, presc_d;
  logic [2:0]  which_q, which_d;
  logic [3:0]  nib;
  logic [7:0]  hex;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    f = '0;
    cf = 1'b0;
    of = 1'b0;
    case (alu_op)
      3'b000: f = a & b;
      3'b001: f = a | b;
      3'b010: f = a ^ b;
      3'b011: f = ~(a | b);
      3'b100: begin
        f = sum[31:0];
        cf = sum[32];
        of = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      3'b101: begin
        f = diff[31:0];
        cf = diff[32];
        of = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      3'b110: f = {31'b0, $signed(a) < $signed(b)};
      default: f = b << a[4:0];
    endcase
    zf = f == '0;
    sf = f[31];
    pf = ~^f;
  end
  always_comb begin
    presc_d = (presc_q == LAST) ? '0 : presc_q + 20'd1;
    which_d = (presc_q == LAST) ? which_q + 3'd1 : which_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      which_q <= '0;
    end else begin
      presc_q <= presc_d;
      which_q <= which_d;
    end
  end
  assign which = which_q;
  assign nib = disp_data[{which_q, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'h0: hex = 8'hC0;
      4'h1: hex = 8'hF9;
      4'h2: hex = 8'hA4;
      4'h3: hex = 8'hB0;
      4'h4: hex = 8'h99;
      4'h5: hex = 8'h92;
      4'h6: hex = 8'h82;
      4'h7: hex = 8'hF8;
      4'h8: hex = 8'h80;
      4'h9: hex = 8'h90;
      4'hA: hex = 8'h88;
      4'hB: hex = 8'h83;
      4'hC: hex = 8'hC6;
      4'hD: hex = 8'hA1;
      4'hE: hex = 8'h86;
      default: hex = 8'h8E;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    seg = (which_q != 3'd0 && (disp_data >> {which_q, 2'b00}) == 32'd0) ? 8'hFF : hex;
`else
    seg = hex;
`endif
  end
endmodule

// File: tb/tb_alu_num_display.sv
// tb_alu_num_display: directed checks of the ALU vectors and the digit scan with SCAN_DIV=4.
module tb_alu_num_display;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  alu_op = '0;
  logic [31:0] a = '0, b = '0, disp_data = '0;
  logic [31:0] f;
  logic        zf, of, sf, cf, pf;
  logic [2:0]  which;
  logic [7:0]  seg;
  int n_chk = 0, n_err = 0;

  alu_num_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .a(a), .b(b), .f(f),
    .zf(zf), .of(of), .sf(sf), .cf(cf), .pf(pf),
    .disp_data(disp_data), .which(which), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] ef, input logic [4:0] efl);
    alu_op = op; a = va; b = vb;
    #1;
    chk({tag, ".f"}, f, ef);
    chk({tag, ".flags"}, {27'b0, zf, of, sf, cf, pf}, {27'b0, efl});
  endtask

  task automatic scan(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                      input logic [7:0] ehi);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("%s.which%0d", tag, d), {29'b0, which}, d);
      chk($sformatf("%s.seg%0d", tag, d), {24'b0, seg}, {24'b0, d == 0 ? e0 : d == 1 ? e1 : d == 2 ? e2 : ehi});
      repeat (4) tick();
    end
  endtask

  logic [7:0] hx [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial begin
    // flags packed as {zf,of,sf,cf,pf}
    alu("add_ovf",  3'b100, 32'h7FFFFFFF, 32'h1,        32'h80000000, 5'b01100);
    alu("add_carry",3'b100, 32'hFFFFFFFF, 32'h1,        32'h0,        5'b10011);
    alu("sub_brw",  3'b101, 32'h3,        32'h5,        32'hFFFFFFFE, 5'b00110);
    alu("sub_ovf",  3'b101, 32'h80000000, 32'h1,        32'h7FFFFFFF, 5'b01000);
    alu("sub_pos",  3'b101, 32'h5,        32'h3,        32'h2,        5'b00000);
    alu("slt_neg",  3'b110, 32'hFFFFFFFF, 32'h0,        32'h1,        5'b00000);
    alu("slt_ge",   3'b110, 32'h5,        32'hFFFFFFFF, 32'h0,        5'b10001);
    alu("sll",      3'b111, 32'h4,        32'hF,        32'hF0,       5'b00001);
    alu("sll_mask", 3'b111, 32'h21,       32'h80000001, 32'h2,        5'b00000);
    alu("nor",      3'b011, 32'h0,        32'h0,        32'hFFFFFFFF, 5'b00101);
    alu("and",      3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00101);
    alu("or",       3'b001, 32'h1,        32'h2,        32'h3,        5'b00001);
    alu("xor",      3'b010, 32'hFFFF0000, 32'hFFFF0000, 32'h0,        5'b10001);

    disp_data = 32'h1234ABCD;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int d = 0; d < 8; d++)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("scan.which%0d_%0d", d, k), {29'b0, which}, d);
        chk($sformatf("scan.seg%0d_%0d", d, k), {24'b0, seg}, {24'b0, hx[(32'h1234ABCD >> (4 * d)) & 32'hF]});
        tick();
      end
    chk("scan.wrap", {29'b0, which}, 0);
    disp_data = 32'h0000000E;
    #1 chk("scan.live_seg", {24'b0, seg}, 32'h86);
    disp_data = 32'h1234ABCD;

    begin
      int t = 0;
      while (which != 3'd5 && t < 100) begin tick(); t++; end
      chk("rst.reach5", {29'b0, which}, 5);
    end
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst.which0", {29'b0, which}, 0);
    chk("rst.seg0", {24'b0, seg}, 32'hA1);
    repeat (3) tick();
    chk("rst.dwell", {29'b0, which}, 0);
    tick();
    chk("rst.next", {29'b0, which}, 1);

    disp_data = 32'h00000A05;
`ifdef LEADING_ZERO_BLANK_EN
    scan("blank_a05", 8'h92, 8'hC0, 8'h88, 8'hFF);
    disp_data = 32'h0;
    scan("blank_zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
    scan("full_a05", 8'h92, 8'hC0, 8'h88, 8'hC0);
    disp_data = 32'h0;
    scan("full_zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
